// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared types and constant helpers for the conv stream feeder.
//   - feeder_state_e : layer FSM states (IDLE / RUN / FINISH)
//   - padded_size    : padded IFM side length
//   - ifm_elems      : IFM elements streamed per layer (replayed per output channel)
//   - wgt_elems      : weights streamed per layer
//   - addr_w         : bits needed to index a table of the given depth (minimum 1)
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } feeder_state_e;

   function automatic int unsigned padded_size(input int unsigned size, input int unsigned pad);
      return size + 2 * pad;
   endfunction

   function automatic int unsigned ifm_elems(input int unsigned co, input int unsigned ci,
                                             input int unsigned size, input int unsigned pad);
      return co * ci * padded_size(size, pad) * padded_size(size, pad);
   endfunction

   function automatic int unsigned wgt_elems(input int unsigned co, input int unsigned ci,
                                             input int unsigned k);
      return co * ci * k * k;
   endfunction

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// feeder_addr_gen
//   Nested wrap counters (out / mid / row / col, col innermost) with pad flag
//   and incrementally generated linear memory address for one stream.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clear      : restart the stream from element 0
//     adv        : current element accepted, step to the next one
//     addr       : memory address of the current element (meaningful when !pad)
//     pad        : current element lies in the zero border
//     exhausted  : final element has been accepted
module feeder_addr_gen
   import conv_pkg::*;
#(
   parameter int unsigned N_OUT    = 1,
   parameter int unsigned N_MID    = 1,
   parameter int unsigned N_ROW    = 1,
   parameter int unsigned N_COL    = 1,
   parameter int unsigned PAD      = 0,
   parameter int unsigned SIZE_ROW = 1,
   parameter int unsigned SIZE_COL = 1,
   parameter int unsigned ADDR_W   = 1,
   parameter bit          REPLAY   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr,
   output logic              pad,
   output logic              exhausted
);

   localparam int unsigned OW = addr_w(N_OUT);
   localparam int unsigned MW = addr_w(N_MID);
   localparam int unsigned RW = addr_w(N_ROW);
   localparam int unsigned CW = addr_w(N_COL);

   logic [OW-1:0]     out_q, out_d;
   logic [MW-1:0]     mid_q, mid_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              exh_q, exh_d;

   logic out_last, mid_last, row_last, col_last;

   assign out_last = (out_q == OW'(N_OUT - 1));
   assign mid_last = (mid_q == MW'(N_MID - 1));
   assign row_last = (row_q == RW'(N_ROW - 1));
   assign col_last = (col_q == CW'(N_COL - 1));

   generate
      if (PAD == 0) begin : g_nopad
         assign pad = 1'b0;
      end else begin : g_pad
         assign pad = (row_q < RW'(PAD)) || (row_q >= RW'(PAD + SIZE_ROW)) ||
                      (col_q < CW'(PAD)) || (col_q >= CW'(PAD + SIZE_COL));
      end
   endgenerate

   // Non-pad elements of one mid block are contiguous in memory and mid blocks
   // follow each other, so the address is a running count of non-pad elements.
   // In REPLAY mode each outer pass re-reads the same region, so it restarts at 0.
   always_comb begin
      out_d  = out_q;
      mid_d  = mid_q;
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      exh_d  = exh_q;
      if (clear) begin
         out_d  = '0;
         mid_d  = '0;
         row_d  = '0;
         col_d  = '0;
         addr_d = '0;
         exh_d  = 1'b0;
      end else if (adv && !exh_q) begin
         if (!pad) begin
            addr_d = addr_q + ADDR_W'(1);
         end
         col_d = col_q + CW'(1);
         if (col_last) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_last) begin
               row_d = '0;
               mid_d = mid_q + MW'(1);
               if (mid_last) begin
                  mid_d = '0;
                  out_d = out_q + OW'(1);
                  if (REPLAY) begin
                     addr_d = '0;
                  end
                  if (out_last) begin
                     out_d = '0;
                     exh_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         mid_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
         exh_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         mid_q  <= mid_d;
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
         exh_q  <= exh_d;
      end
   end

   assign addr      = addr_q;
   assign exhausted = exh_q;

endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder
//   Answers the transposed-conv engine's ifm_read / wgt_read strobes with one
//   element each, returned through a register one cycle after the SRAM read.
//   Zero border elements are synthesised without an SRAM access. The IFM is
//   re-streamed once per output channel.
//   Ports:
//     clk1, rst                      : clock, synchronous active-high reset
//     start                          : arm a new layer, clear all counters
//     ifm_read / wgt_read            : engine strobes
//     ifm / wgt                      : returned elements (hold until next return)
//     ifm_mem_re/addr/rdata          : IFM SRAM port (one-cycle read latency)
//     wgt_mem_re/addr/rdata          : weight SRAM port (one-cycle read latency)
//     busy                           : layer in RUN or FINISH
//     done                           : one-cycle pulse when both streams delivered
//     overrun                        : sticky excess-strobe flag, present only when
//                                      FEEDER_OVERRUN_CHECK_EN is defined
module conv_stream_feeder
   import conv_pkg::*;
#(
   parameter int unsigned IFM_WIDTH    = 16,
   parameter int unsigned WEIGHT_WIDTH = 16,
   parameter int unsigned IFM_SIZE     = 64,
   parameter int unsigned KERNEL_SIZE  = 5,
   parameter int unsigned PAD          = 2,
   parameter int unsigned CI           = 3,
   parameter int unsigned CO           = 8,
   parameter int unsigned IFM_ADDR_W   = addr_w(CI * IFM_SIZE * IFM_SIZE),
   parameter int unsigned WGT_ADDR_W   = addr_w(CO * CI * KERNEL_SIZE * KERNEL_SIZE)
) (
   input  logic                    clk1,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    ifm_read,
   input  logic                    wgt_read,
   output logic [IFM_WIDTH-1:0]    ifm,
   output logic [WEIGHT_WIDTH-1:0] wgt,
   output logic                    ifm_mem_re,
   output logic [IFM_ADDR_W-1:0]   ifm_mem_addr,
   input  logic [IFM_WIDTH-1:0]    ifm_mem_rdata,
   output logic                    wgt_mem_re,
   output logic [WGT_ADDR_W-1:0]   wgt_mem_addr,
   input  logic [WEIGHT_WIDTH-1:0] wgt_mem_rdata,
   output logic                    busy,
   output logic                    done
`ifdef FEEDER_OVERRUN_CHECK_EN
   ,
   output logic                    overrun
`endif
);

   localparam int unsigned PS = padded_size(IFM_SIZE, PAD);
   localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;

   feeder_state_e state_q, state_d;

   logic                    ifm_vld_q, ifm_vld_d;
   logic                    ifm_pad_q, ifm_pad_d;
   logic [IFM_WIDTH-1:0]    ifm_q, ifm_d;
   logic                    wgt_vld_q, wgt_vld_d;
   logic [WEIGHT_WIDTH-1:0] wgt_q, wgt_d;

   logic                  run;
   logic                  ifm_acc, wgt_acc;
   logic                  ifm_pad, ifm_exh, wgt_exh;
   logic [IFM_ADDR_W-1:0] ifm_addr;
   logic [WGT_ADDR_W-1:0] wgt_addr;
   logic                  wgt_pad_unused;

   // A start in the same cycle as a strobe wins; the strobe is dropped.
   assign run     = (state_q == ST_RUN) && !start;
   assign ifm_acc = run && ifm_read && !ifm_exh;
   assign wgt_acc = run && wgt_read && !wgt_exh;

   feeder_addr_gen #(
      .N_OUT    (CO),
      .N_MID    (CI),
      .N_ROW    (PS),
      .N_COL    (PS),
      .PAD      (PAD),
      .SIZE_ROW (IFM_SIZE),
      .SIZE_COL (IFM_SIZE),
      .ADDR_W   (IFM_ADDR_W),
      .REPLAY   (1'b1)
   ) u_ifm_gen (
      .clk       (clk1),
      .rst       (rst),
      .clear     (start),
      .adv       (ifm_acc),
      .addr      (ifm_addr),
      .pad       (ifm_pad),
      .exhausted (ifm_exh)
   );

   feeder_addr_gen #(
      .N_OUT    (CO),
      .N_MID    (CI),
      .N_ROW    (1),
      .N_COL    (KK),
      .PAD      (0),
      .SIZE_ROW (1),
      .SIZE_COL (KK),
      .ADDR_W   (WGT_ADDR_W),
      .REPLAY   (1'b0)
   ) u_wgt_gen (
      .clk       (clk1),
      .rst       (rst),
      .clear     (start),
      .adv       (wgt_acc),
      .addr      (wgt_addr),
      .pad       (wgt_pad_unused),
      .exhausted (wgt_exh)
   );

   assign ifm_mem_re   = ifm_acc && !ifm_pad;
   assign ifm_mem_addr = ifm_mem_re ? ifm_addr : '0;
   assign wgt_mem_re   = wgt_acc;
   assign wgt_mem_addr = wgt_mem_re ? wgt_addr : '0;

   // FSM: FINISH only once both streams are exhausted and no return is in flight.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_RUN:    if (ifm_exh && wgt_exh && !ifm_vld_q && !wgt_vld_q) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Return path: SRAM data arrives the cycle after the read, then is registered.
   always_comb begin
      ifm_vld_d = ifm_acc;
      ifm_pad_d = ifm_acc && ifm_pad;
      ifm_d     = ifm_q;
      if (ifm_vld_q) begin
         ifm_d = ifm_pad_q ? '0 : ifm_mem_rdata;
      end
      wgt_vld_d = wgt_acc;
      wgt_d     = wgt_q;
      if (wgt_vld_q) begin
         wgt_d = wgt_mem_rdata;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ifm_vld_q <= 1'b0;
         ifm_pad_q <= 1'b0;
         ifm_q     <= '0;
         wgt_vld_q <= 1'b0;
         wgt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ifm_vld_q <= ifm_vld_d;
         ifm_pad_q <= ifm_pad_d;
         ifm_q     <= ifm_d;
         wgt_vld_q <= wgt_vld_d;
         wgt_q     <= wgt_d;
      end
   end

   assign ifm  = ifm_q;
   assign wgt  = wgt_q;
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_FINISH);

`ifdef FEEDER_OVERRUN_CHECK_EN
   logic overrun_q, overrun_d;
   logic ifm_excess, wgt_excess;

   assign ifm_excess = ifm_read && ((state_q == ST_IDLE) || ((state_q == ST_RUN) && ifm_exh));
   assign wgt_excess = wgt_read && ((state_q == ST_IDLE) || ((state_q == ST_RUN) && wgt_exh));

   always_comb begin
      overrun_d = overrun_q;
      if (start) begin
         overrun_d = 1'b0;
      end else if (ifm_excess || wgt_excess) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
Responder to the transposed-convolution engine's read strobes (ifm_read, wgt_read). It generates addresses into the IFM and weight SRAMs and returns one element per strobe, one cycle later. It synthesises the zero border for PAD positions without touching memory. It sits between the on-chip feature/weight SRAMs and the conv engine's ifm/wgt inputs, and re-streams the IFM once per output channel.

Parameters:
IFM_WIDTH, 16, IFM element width
WEIGHT_WIDTH, 16, weight element width
IFM_SIZE, 64, unpadded IFM height/width
KERNEL_SIZE, 5, kernel height/width
PAD, 2, zero border per side; padded side PS = IFM_SIZE+2*PAD
CI, 3, input channels
CO, 8, output channels
IFM_ADDR_W, $clog2(CI*IFM_SIZE*IFM_SIZE), IFM SRAM address width
WGT_ADDR_W, $clog2(CO*CI*KERNEL_SIZE*KERNEL_SIZE), weight SRAM address width

Ports:
clk1  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; arms a new layer and clears all counters
ifm_read  in  1  engine requests next IFM element
wgt_read  in  1  engine requests next weight
ifm  out  IFM_WIDTH  IFM element to engine
wgt  out  WEIGHT_WIDTH  weight to engine
ifm_mem_re  out  1  IFM SRAM read enable
ifm_mem_addr  out  IFM_ADDR_W  IFM SRAM address
ifm_mem_rdata  in  IFM_WIDTH  IFM SRAM data, valid one cycle after ifm_mem_re
wgt_mem_re  out  1  weight SRAM read enable
wgt_mem_addr  out  WGT_ADDR_W  weight SRAM address
wgt_mem_rdata  in  WEIGHT_WIDTH  weight SRAM data, one-cycle latency
busy  out  1  layer in progress
done  out  1  one-cycle pulse when both streams are fully delivered

Behaviour:
- Reset (rst=1 at a clk1 edge): ifm=0, wgt=0, ifm_mem_re=0, wgt_mem_re=0, both addresses 0, busy=0, done=0, all counters 0. Reset mid-layer abandons the layer; no done pulse.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on start.
  - RUN -> FINISH when both streams have been exhausted and the last return has been registered.
  - FINISH: done=1 for one cycle, then IDLE.
  - start while in RUN or FINISH restarts: counters cleared, stay or go to RUN, no done pulse.
- busy=1 in RUN and FINISH.
- Read strobes are ignored in IDLE and after their stream is exhausted.
- IFM stream order, outermost first: co (0..CO-1, replay), ci, row r (0..PS-1), col c (0..PS-1). Total CO*CI*PS*PS elements.
- Pad position: r<PAD, r>=PAD+IFM_SIZE, c<PAD, or c>=PAD+IFM_SIZE.
- IFM strobe handling, ifm_read=1 in cycle t:
  - Non-pad position: ifm_mem_re=1 combinationally in t, with ifm_mem_addr = ci*IFM_SIZE^2 + (r-PAD)*IFM_SIZE + (c-PAD).
  - Pad position: ifm_mem_re=0.
  - In t+1, the ifm register loads ifm_mem_rdata, or 0 for a pad position (pad flag pipelined one stage).
  - ifm holds its value until the next return.
- Weight stream order: co, ci, k (0..K*K-1). wgt_mem_addr = linear index (co*CI+ci)*K*K + k. Same one-cycle return rule; wgt_mem_re=1 on every accepted wgt_read.
- Back-to-back strobes every cycle are supported on both streams.
- ifm_read and wgt_read may be asserted in the same cycle; the streams are fully independent.
- Counters use nested wrap: c wraps PS-1->0 and increments r; r wraps and increments ci; ci wraps and increments co. Weight counters use the same scheme.
- Address arithmetic is unsigned. Multiplies by constants are computed incrementally: a running base is added to on counter wrap. No runtime multipliers.
- A stream is exhausted when its final element has been accepted.

Optional Feature:
Macro FEEDER_OVERRUN_CHECK_EN.
- Defined: adds output port overrun (1 bit, sticky, reset 0, cleared by start). It sets when ifm_read or wgt_read is asserted in RUN after that stream is exhausted, or while IDLE. The strobe is still ignored.
- Undefined: no port, no logic; excess strobes are silently ignored.

Decomposition:
- Shared package conv_pkg: FSM state enum (IDLE/RUN/FINISH), padded-size and element-count constant functions, address width helpers.
- One natural sub-module, feeder_addr_gen: nested wrap counters plus incremental address and pad flag. Instantiated twice, IFM mode and weight mode (weight mode with PAD=0 and a K*K inner extent).

Test Plan:
Common parameters: IFM_SIZE=4, PAD=1, KERNEL_SIZE=3, CI=2, CO=2 (PS=6, 144 IFM reads, 36 weight reads).
1. Reset then start, then ifm_read held 1 for 8 cycles -> reads 0..6 produce ifm_mem_re=0 and ifm=0. Read 7 (r1,c1) gives ifm_mem_re=1, addr=0, and ifm=mem[0] one cycle later.
2. All 144 IFM reads against mem[a]=a+1 -> returned sequence matches the padded-ordering model, including the second co pass replaying identical addresses. Read 43 (ci1,r1,c1) gives addr 16.
3. 36 wgt_read pulses with gaps, interleaved with ifm_read in the same cycles -> wgt_mem_addr 0..35 in order. Both streams are correct, and done pulses exactly once, one cycle after the later final return.
4. Assert rst on the 50th IFM read -> all outputs 0 next cycle and no done. A new start restarts from addr 0 with a pad zero.
5. start asserted mid-RUN -> counters clear, next IFM read returns a pad zero, no done for the aborted layer.
6. FEEDER_OVERRUN_CHECK_EN: a 145th ifm_read -> overrun=1 and ifm unchanged. Next start clears overrun to 0.
